// File: rtl/mpx_divider.sv
// mpx_divider: iterative 32-bit restoring divider for MIPS DIV/DIVU (quotient to LO, remainder to HI)
// Define MPX_DIV_EARLY_OUT_EN to skip iteration when divisor is zero or |dividend| < |divisor|.
module mpx_divider (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  logic        signed_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] quo_q, rem_q, dvs_q, dvd_abs, dvs_abs;
   logic        q_neg_q, r_neg_q, start, early;
   logic [32:0] shifted;
   logic [33:0] diff;
   assign start   = state_q == IDLE && valid_i && !abort_i;
   assign dvd_abs = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
   assign dvs_abs = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
`ifdef MPX_DIV_EARLY_OUT_EN
   assign early = divisor_i == '0 || dvd_abs < dvs_abs;
`else
   assign early = 1'b0;
`endif
   // quo_q starts as the dividend and fills with quotient bits as dividend bits shift out the top
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
   assign busy_o  = state_q != IDLE;
   always_ff @(posedge clk_i) state_q <= !rst_ni ? IDLE : state_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = start ? (early ? FIXUP : CALC) : IDLE;
         CALC:    state_d = cnt_q == 5'd31 ? FIXUP : CALC;
         FIXUP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_i) state_d = IDLE;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         valid_o     <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
      end else begin
         valid_o <= 1'b0;
         if (start) begin
            cnt_q   <= '0;
            quo_q   <= early ? {32{divisor_i == '0}} : dvd_abs;
            rem_q   <= early ? dvd_abs : '0;
            dvs_q   <= dvs_abs;
            q_neg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]);
            r_neg_q <= signed_i & dividend_i[31];
         end else if (state_q == CALC && !abort_i) begin
            cnt_q <= cnt_q + 5'd1;
            rem_q <= diff[33] ? shifted[31:0] : diff[31:0];
            quo_q <= {quo_q[30:0], ~diff[33]};
         end else if (state_q == FIXUP && !abort_i) begin
            valid_o     <= 1'b1;
            quotient_o  <= q_neg_q ? -quo_q : quo_q;
            remainder_o <= r_neg_q ? -rem_q : rem_q;
         end
      end
   end
endmodule

// File: tb/tb_mpx_divider.sv
// tb_mpx_divider: directed and randomized checks of mpx_divider against an arithmetic reference model.
module tb_mpx_divider;
   logic        clk_i = 0, rst_ni = 0, valid_i = 0, signed_i = 0, abort_i = 0;
   logic [31:0] dividend_i = 0, divisor_i = 0;
   logic        busy_o, valid_o;
   logic [31:0] quotient_o, remainder_o;
   int tests = 0, fails = 0;
   mpx_divider dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .abort_i(abort_i),
      .busy_o(busy_o), .valid_o(valid_o), .quotient_o(quotient_o), .remainder_o(remainder_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      logic [31:0] q, r;
      if (b == 0) begin
         r = a;
         q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
         q = 32'(x / y);
         r = 32'(x % y);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction
   function automatic int exp_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef MPX_DIV_EARLY_OUT_EN
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      return (b == 0 || ma < mb) ? 1 : 33;
`else
      return 33;
`endif
   endfunction
   task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk_i);
      valid_i = 1; signed_i = s; dividend_i = a; divisor_i = b;
      @(posedge clk_i);
      #1 valid_i = 0;
   endtask
   task automatic wait_done(input int lat, input logic [31:0] q, input logic [31:0] r);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk_i);
         n++;
         #1;
         if (valid_o) seen = 1;
         else check("busy", 32'(busy_o), 32'd1);
      end
      check("latency", 32'(n), 32'(lat));
      check("quotient", quotient_o, q);
      check("remainder", remainder_o, r);
   endtask
   task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r);
      start_op(s, a, b);
      wait_done(exp_lat(s, a, b), q, r);
      @(posedge clk_i);
      #1 check("pulse", 32'(valid_o), 32'd0);
   endtask
   task automatic count_valid(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(posedge clk_i);
         #1 if (valid_o) cnt++;
      end
   endtask
   typedef struct {bit s; logic [31:0] a, b, q, r;} vec_t;
   vec_t vecs[$] = '{
      '{0, 32'd100,        32'd7,          32'd14,         32'd2},
      '{1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE},
      '{1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2},
      '{0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5},
      '{1, 32'hFFFFFFFB,   32'd0,          32'd1,          32'hFFFFFFFB},
      '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0},
      '{0, 32'd3,          32'd10,         32'd0,          32'd3},
      '{0, 32'd9,          32'd3,          32'd3,          32'd0}
   };
   initial begin
      int cnt;
      logic [63:0] e;
      logic [31:0] a, b;
      bit s;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_quot", quotient_o, 32'd0);
      check("rst_rem", remainder_o, 32'd0);
      @(negedge clk_i) rst_ni = 1;
      foreach (vecs[i]) run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      // abort mid-calculation: outputs keep the 9/3 result
      start_op(0, 32'd8, 32'd2);
      repeat (9) @(posedge clk_i);
      @(negedge clk_i) abort_i = 1;
      @(posedge clk_i);
      #1 abort_i = 0;
      check("abort_busy", 32'(busy_o), 32'd0);
      count_valid(40, cnt);
      check("abort_novalid", 32'(cnt), 32'd0);
      check("abort_quot", quotient_o, 32'd3);
      check("abort_rem", remainder_o, 32'd0);
      run_op(0, 32'd8, 32'd2, 32'd4, 32'd0);
      // abort beats valid in IDLE
      @(negedge clk_i);
      valid_i = 1; abort_i = 1; dividend_i = 32'd50; divisor_i = 32'd3;
      @(posedge clk_i);
      #1 valid_i = 0; abort_i = 0;
      check("abort_idle_busy", 32'(busy_o), 32'd0);
      // valid held high with operands changing mid-flight; second op accepted on the pulse cycle
      @(negedge clk_i);
      valid_i = 1; signed_i = 0; dividend_i = 32'd1000; divisor_i = 32'd10;
      @(posedge clk_i);
      #1 dividend_i = 32'd77; divisor_i = 32'd5;
      wait_done(33, 32'd100, 32'd0);
      @(posedge clk_i);
      #1 valid_i = 0;
      check("back2back_busy", 32'(busy_o), 32'd1);
      wait_done(33, 32'd15, 32'd2);
      // reset mid-operation
      start_op(0, 32'hFFFFFFFF, 32'd3);
      repeat (19) @(posedge clk_i);
      @(negedge clk_i) rst_ni = 0;
      @(posedge clk_i);
      #1;
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_valid", 32'(valid_o), 32'd0);
      check("midrst_quot", quotient_o, 32'd0);
      check("midrst_rem", remainder_o, 32'd0);
      @(negedge clk_i) rst_ni = 1;
      count_valid(40, cnt);
      check("midrst_novalid", 32'(cnt), 32'd0);
      for (int i = 0; i < 150; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF;
            3: b = a >> $urandom_range(0, 31);
            4: begin a = 32'h80000000; b = $urandom; end
            5: b = a + 32'd1;
            default: b = $urandom;
         endcase
         e = ref_div(s, a, b);
         run_op(s, a, b, e[63:32], e[31:0]);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
